// File: rtl/rt_line_ctrl.sv
// Racetrack line controller: sequences shift/write/read/limit pulses for one line.
// Optional macro RT_LINE_CTRL_POS_EN enables line-offset tracking and a SHIFT range check.
module rt_line_ctrl #(
    parameter int Np        = 8,
    parameter int Nsp       = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [2:0]               cmd_op_i,
    input  logic                     cmd_dir_i,
    input  logic [$clog2(Nsp):0]     cmd_cnt_i,
    input  logic [3:0]               cmd_trk_i,
    input  logic [2:0]               cmd_wbit_i,
    input  logic [Np-1:0]            cmd_port_i,
    output logic [3:0]               current_s_o,
    output logic [3:0]               current_m_o,
    output logic                     Bz_s_o,
    output logic                     Bz_m_o,
    output logic                     read_current_o,
    output logic [2:0]               write_i_o,
    output logic [3*Np-1:0]          write_en_o,
    input  logic [4*Np-1:0]          r_port_i,
    output logic                     rsp_valid_o,
    output logic                     rsp_err_o,
    output logic [4*Np-1:0]          rsp_rdata_o,
    output logic [$clog2(Nsp)-1:0]   pos_o
);
    localparam int PW   = $clog2(Nsp);
    localparam int CW   = PW + 1;
    localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SHIFT = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;
    localparam logic [2:0] OP_LIM   = 3'd4;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]      op_q;
    logic            dir_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      trk_q;
    logic [2:0]      wbit_q;
    logic [Np-1:0]   port_q;
    logic            err_q;
    logic [TW-1:0]   tcnt_q;
    logic [CW-1:0]   step_q;
    logic [4*Np-1:0] rdata_q;

    logic pulse_last, gap_last, step_last, range_err, setup_err;

    assign pulse_last = (tcnt_q == TW'(PULSE_CYC - 1));
    assign gap_last   = (tcnt_q == TW'(GAP_CYC - 1));
    assign step_last  = (step_q == cnt_q - CW'(1));

`ifdef RT_LINE_CTRL_POS_EN
    localparam logic signed [PW+2:0] POS_MAX = (PW+3)'(Nsp - 1);
    logic [PW-1:0]          pos_q;
    logic signed [PW+2:0]   pos_tgt;

    // Target offset after the whole SHIFT, computed signed so both ends can be checked.
    always_comb begin
        if (dir_q)
            pos_tgt = signed'({3'b000, pos_q}) - signed'({2'b00, cnt_q});
        else
            pos_tgt = signed'({3'b000, pos_q}) + signed'({2'b00, cnt_q});
    end
    assign range_err = (pos_tgt < 0) || (pos_tgt > POS_MAX);
    assign pos_o     = pos_q;
`else
    assign range_err = 1'b0;
    assign pos_o     = '0;
`endif

    assign setup_err   = (op_q > OP_LIM) || ((op_q == OP_SHIFT) && range_err);
    assign rsp_rdata_o = rdata_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op_q    <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            trk_q   <= '0;
            wbit_q  <= '0;
            port_q  <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
            step_q  <= '0;
            rdata_q <= '0;
`ifdef RT_LINE_CTRL_POS_EN
            pos_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q   <= cmd_op_i;
                        dir_q  <= cmd_dir_i;
                        cnt_q  <= cmd_cnt_i;
                        trk_q  <= cmd_trk_i;
                        wbit_q <= cmd_wbit_i;
                        port_q <= cmd_port_i;
                        err_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    err_q  <= setup_err;
                    tcnt_q <= '0;
                    step_q <= '0;
                end
                PULSE: begin
                    tcnt_q <= pulse_last ? '0 : tcnt_q + 1'b1;
                    if ((op_q == OP_READ) && pulse_last) rdata_q <= r_port_i;
                end
                GAP: begin
                    if (gap_last) begin
                        tcnt_q <= '0;
                        step_q <= step_q + 1'b1;
`ifdef RT_LINE_CTRL_POS_EN
                        if (step_last) pos_q <= pos_tgt[PW-1:0];
`endif
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        cmd_ready_o    = 1'b0;
        current_s_o    = '0;
        current_m_o    = '0;
        Bz_s_o         = 1'b0;
        Bz_m_o         = 1'b0;
        read_current_o = 1'b0;
        write_i_o      = '0;
        write_en_o     = '0;
        rsp_valid_o    = 1'b0;
        rsp_err_o      = 1'b0;

        // Static levels are set up one cycle ahead of the pulse and held until DONE.
        if (state_q == SETUP || state_q == PULSE || state_q == GAP) begin
            if (op_q == OP_SHIFT) current_s_o = trk_q & {4{dir_q}};
            if (op_q == OP_WRITE) write_i_o   = wbit_q;
            if (op_q == OP_LIM)   Bz_s_o      = dir_q;
        end

        case (state_q)
            IDLE: begin
                cmd_ready_o = rstn_i;
                if (cmd_valid_i) state_d = SETUP;
            end
            SETUP: begin
                if (setup_err || (op_q == OP_NOP) || ((op_q == OP_SHIFT) && (cnt_q == '0)))
                    state_d = DONE;
                else
                    state_d = PULSE;
            end
            PULSE: begin
                case (op_q)
                    OP_SHIFT: current_m_o    = trk_q;
                    OP_WRITE: write_en_o     = {{Np{trk_q[3]}} & port_q,
                                                {Np{trk_q[2]}} & port_q,
                                                {Np{trk_q[1]}} & port_q};
                    OP_READ:  read_current_o = 1'b1;
                    OP_LIM:   Bz_m_o         = 1'b1;
                    default: ;
                endcase
                if (pulse_last) state_d = (op_q == OP_SHIFT) ? GAP : DONE;
            end
            GAP: begin
                if (gap_last) state_d = step_last ? DONE : PULSE;
            end
            DONE: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rt_line_ctrl.sv
// Self-checking bench for rt_line_ctrl: table of commands, per-cycle waveform model and
// a response scoreboard, plus reset and (with RT_LINE_CTRL_POS_EN) offset range sequences.
module tb_rt_line_ctrl;
    localparam int NP = 8;
    localparam int NSP = 4;
    localparam int P = 2;
    localparam int G = 1;

    logic              clk = 1'b0;
    logic              rstn_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [2:0]        cmd_op_i;
    logic              cmd_dir_i;
    logic [2:0]        cmd_cnt_i;
    logic [3:0]        cmd_trk_i;
    logic [2:0]        cmd_wbit_i;
    logic [NP-1:0]     cmd_port_i;
    logic [3:0]        current_s_o, current_m_o;
    logic              Bz_s_o, Bz_m_o, read_current_o;
    logic [2:0]        write_i_o;
    logic [3*NP-1:0]   write_en_o;
    logic [4*NP-1:0]   r_port_i;
    logic              rsp_valid_o, rsp_err_o;
    logic [4*NP-1:0]   rsp_rdata_o;
    logic [1:0]        pos_o;

    rt_line_ctrl #(.Np(NP), .Nsp(NSP), .PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_dir_i(cmd_dir_i), .cmd_cnt_i(cmd_cnt_i), .cmd_trk_i(cmd_trk_i),
        .cmd_wbit_i(cmd_wbit_i), .cmd_port_i(cmd_port_i), .current_s_o(current_s_o),
        .current_m_o(current_m_o), .Bz_s_o(Bz_s_o), .Bz_m_o(Bz_m_o),
        .read_current_o(read_current_o), .write_i_o(write_i_o), .write_en_o(write_en_o),
        .r_port_i(r_port_i), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
        .rsp_rdata_o(rsp_rdata_o), .pos_o(pos_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        dir;
        logic [2:0]  cnt;
        logic [3:0]  trk;
        logic [2:0]  wbit;
        logic [7:0]  port;
        logic [31:0] rport;
        int          lat;
        logic        err;
    } vec_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t        tbl[14];
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rdata = '0;
    int          pos_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic dir, input logic [2:0] cnt,
                                input logic [3:0] trk, input logic [2:0] wbit,
                                input logic [7:0] port, input logic [31:0] rport,
                                input int lat, input logic err);
        vec_t v;
        v.op = op; v.dir = dir; v.cnt = cnt; v.trk = trk; v.wbit = wbit;
        v.port = port; v.rport = rport; v.lat = lat; v.err = err;
        return v;
    endfunction

    task automatic run_cmd(input vec_t v);
        exp_t        e;
        logic        pulse;
        logic        done;
        int          per;
        logic [3:0]  cm_e;
        logic [23:0] we_e;
        per = P + G;
        @(negedge clk);
        chk("ready_idle", 64'(cmd_ready_o), 64'd1);
        cmd_valid_i = 1'b1; cmd_op_i = v.op; cmd_dir_i = v.dir; cmd_cnt_i = v.cnt;
        cmd_trk_i = v.trk; cmd_wbit_i = v.wbit; cmd_port_i = v.port; r_port_i = v.rport;
        e.lat = v.lat;
        e.err = v.err;
        e.rdata = (v.op == 3'd3 && !v.err) ? v.rport : last_rdata;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid_i = 1'b0; cmd_op_i = '0;
        done = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            if (v.err) pulse = 1'b0;
            else if (v.op == 3'd1) pulse = (c >= 2) && (c < 2 + int'(v.cnt) * per) && (((c - 2) % per) < P);
            else if (v.op >= 3'd2 && v.op <= 3'd4) pulse = (c >= 2) && (c < 2 + P);
            else pulse = 1'b0;
            cm_e = (v.op == 3'd1 && pulse) ? v.trk : 4'h0;
            we_e = (v.op == 3'd2 && pulse) ?
                   {{8{v.trk[3]}} & v.port, {8{v.trk[2]}} & v.port, {8{v.trk[1]}} & v.port} : 24'h0;
            chk("current_m", 64'(current_m_o), 64'(cm_e));
            chk("write_en", 64'(write_en_o), 64'(we_e));
            chk("read_current", 64'(read_current_o), 64'(v.op == 3'd3 && pulse));
            chk("Bz_m", 64'(Bz_m_o), 64'(v.op == 3'd4 && pulse));
            chk("ready_busy", 64'(cmd_ready_o), 64'd0);
            if (!v.err && c < v.lat) begin
                if (v.op == 3'd1) chk("current_s", 64'(current_s_o), 64'(v.trk & {4{v.dir}}));
                if (v.op == 3'd2) chk("write_i", 64'(write_i_o), 64'(v.wbit));
                if (v.op == 3'd4) chk("Bz_s", 64'(Bz_s_o), 64'(v.dir));
            end
            if (rsp_valid_o) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty: response with no pending command at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 64'(c), 64'(e.lat));
                    chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
                    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                    last_rdata = e.rdata;
                end
`ifdef RT_LINE_CTRL_POS_EN
                if (v.op == 3'd1 && !v.err)
                    pos_model = v.dir ? pos_model - int'(v.cnt) : pos_model + int'(v.cnt);
`endif
                chk("pos", 64'(pos_o), 64'(pos_model));
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL timeout: no rsp_valid op=%0d got none expected cycle %0d", v.op, v.lat);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_dir_i = 1'b0; cmd_cnt_i = '0;
        cmd_trk_i = '0; cmd_wbit_i = '0; cmd_port_i = '0; r_port_i = '0;

        tbl[0]  = mk(3'd1, 1'b0, 3'd3, 4'b0010, 3'b000, 8'h00, 32'h0, 11, 1'b0);
        tbl[1]  = mk(3'd2, 1'b0, 3'd0, 4'b1011, 3'b101, 8'h04, 32'h0, 4, 1'b0);
        tbl[2]  = mk(3'd3, 1'b0, 3'd0, 4'b1111, 3'b000, 8'h00, 32'hA5A5_0F0F, 4, 1'b0);
        tbl[3]  = mk(3'd4, 1'b1, 3'd0, 4'b0001, 3'b000, 8'h00, 32'h0, 4, 1'b0);
        tbl[4]  = mk(3'd0, 1'b0, 3'd0, 4'b1111, 3'b111, 8'hFF, 32'h0, 2, 1'b0);
        tbl[5]  = mk(3'd6, 1'b0, 3'd2, 4'b1111, 3'b111, 8'hFF, 32'h0, 2, 1'b1);
        tbl[6]  = mk(3'd1, 1'b1, 3'd1, 4'b1111, 3'b000, 8'h00, 32'h0, 5, 1'b0);
        tbl[7]  = mk(3'd1, 1'b0, 3'd0, 4'b0110, 3'b000, 8'h00, 32'h0, 2, 1'b0);
        tbl[8]  = mk(3'd2, 1'b0, 3'd0, 4'b1101, 3'b010, 8'h81, 32'h0, 4, 1'b0);
        tbl[9]  = mk(3'd3, 1'b0, 3'd0, 4'b0000, 3'b000, 8'h00, 32'h1234_5678, 4, 1'b0);
        tbl[10] = mk(3'd7, 1'b1, 3'd1, 4'b0010, 3'b000, 8'h00, 32'h0, 2, 1'b1);
        tbl[11] = mk(3'd1, 1'b1, 3'd2, 4'b0100, 3'b000, 8'h00, 32'h0, 8, 1'b0);
        tbl[12] = mk(3'd5, 1'b0, 3'd0, 4'b0000, 3'b000, 8'h00, 32'h0, 2, 1'b1);
        tbl[13] = mk(3'd4, 1'b0, 3'd0, 4'b0001, 3'b000, 8'h00, 32'h0, 4, 1'b0);

        repeat (2) @(negedge clk);
        chk("reset_ctrl", 64'({cmd_ready_o, current_s_o, current_m_o, Bz_s_o, Bz_m_o,
                               read_current_o, write_i_o, write_en_o, rsp_valid_o, rsp_err_o}), 64'd0);
        chk("reset_data", 64'({rsp_rdata_o, pos_o}), 64'd0);
        rstn_i = 1'b1;
        #1;
        chk("ready_after_reset", 64'(cmd_ready_o), 64'd1);

        for (int i = 0; i < 14; i++) run_cmd(tbl[i]);

        // Reset asserted in the middle of a SHIFT pulse.
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_op_i = 3'd1; cmd_dir_i = 1'b0; cmd_cnt_i = 3'd3; cmd_trk_i = 4'b0010;
        @(negedge clk);
        cmd_valid_i = 1'b0; cmd_op_i = '0;
        @(negedge clk);
        chk("midop_pulse", 64'(current_m_o), 64'(4'b0010));
        #1 rstn_i = 1'b0;
        #1;
        chk("midop_reset_ctrl", 64'({cmd_ready_o, current_s_o, current_m_o, Bz_s_o, Bz_m_o,
                                     read_current_o, write_i_o, write_en_o, rsp_valid_o, rsp_err_o}), 64'd0);
        chk("midop_reset_data", 64'({rsp_rdata_o, pos_o}), 64'd0);
        last_rdata = '0;
        pos_model = 0;
        @(negedge clk);
        rstn_i = 1'b1;
        #1;
        chk("midop_ready_release", 64'(cmd_ready_o), 64'd1);
        run_cmd(mk(3'd1, 1'b0, 3'd2, 4'b1000, 3'b000, 8'h00, 32'h0, 8, 1'b0));

`ifdef RT_LINE_CTRL_POS_EN
        run_cmd(mk(3'd1, 1'b0, 3'd1, 4'b0010, 3'b000, 8'h00, 32'h0, 5, 1'b0));
        run_cmd(mk(3'd1, 1'b0, 3'd1, 4'b0010, 3'b000, 8'h00, 32'h0, 2, 1'b1));
        run_cmd(mk(3'd1, 1'b1, 3'd4, 4'b0010, 3'b000, 8'h00, 32'h0, 2, 1'b1));
        run_cmd(mk(3'd1, 1'b1, 3'd3, 4'b0001, 3'b000, 8'h00, 32'h0, 11, 1'b0));
        run_cmd(mk(3'd1, 1'b1, 3'd1, 4'b0001, 3'b000, 8'h00, 32'h0, 2, 1'b1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
